fp32_to_fp16_pipe: RTL
======================

FP32_TO_FP16_PIPE -- requirements
Module: fp32_to_fp16_pipe

Interface
REQ-001 SHALL have parameter LANES, default 4, giving the number of parallel conversion lanes.
REQ-002 SHALL have parameter PARM_RM, default 3, giving the rounding-mode field width.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock; all state on rising edge.
REQ-004 SHALL have port rst_ni, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid_i, input, 1 bit: input beat valid.
REQ-006 SHALL have port in_ready_o, output, 1 bit: input beat accepted when valid and ready are both high.
REQ-007 SHALL have port data_i, input, LANES*32 bits: FP32 operands, lane k at [32k+31:32k].
REQ-008 SHALL have port rm_i, input, PARM_RM bits: rounding mode for the beat.
REQ-009 SHALL have port mode_i, input, 1 bit: 1 = convert, 0 = passthrough.
REQ-010 SHALL have port flags_i, input, LANES*4 bits: per-lane incoming {NV,OF,UF,NX}.
REQ-011 SHALL have port out_valid_o, output, 1 bit: output beat valid.
REQ-012 SHALL have port out_ready_i, input, 1 bit: downstream ready.
REQ-013 SHALL have port result_o, output, LANES*32 bits: per lane, fp16 in [15:0] with [31:16]=0 when converted.
REQ-014 SHALL have port flags_o, output, LANES*4 bits: per-lane {NV,OF,UF,NX} for the beat.
REQ-015 SHALL have port fflags_o, output, 4 bits: sticky OR of all delivered flags.
REQ-016 SHALL have port fflags_clr_i, input, 1 bit: clears fflags_o.

Function
REQ-017 SHALL be a 2-stage pipeline: S1 decode/align, S2 round/pack; an accepted beat appears on out_valid_o exactly 2 cycles later absent backpressure.
REQ-018 SHALL hold stage k when valid and not advancing; in_ready_o = ~v1 | ~v2 | out_ready_i; a combinational path from out_ready_i to in_ready_o is permitted.
REQ-019 SHALL keep output data/flags stable while out_valid_o=1 and out_ready_i=0, with no loss, duplication or reordering; full throughput is one beat per cycle.
REQ-020 SHALL carry rm_i/mode_i with the beat; changing them mid-stream affects only newly accepted beats.
REQ-021 SHALL, in passthrough, output result = data_i and flags_o = flags_i per lane.
REQ-022 SHALL support rm codes 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM; codes 101-111 behave as RNE.
REQ-023 SHALL map ±0 to ±0 with no flags; ±Inf to ±Inf (0x7C00/0xFC00) with no flags.
REQ-024 SHALL map any NaN to a quiet NaN: sign kept, exponent 0x1F, mantissa = man32[22:13] with bit 9 forced to 1; NV is set only for a signalling NaN (man32[22]=0).
REQ-025 SHALL set OF and NX on overflow after rounding; result: RNE/RMM ±Inf; RTZ ±0x7BFF; RDN +0x7BFF/−Inf; RUP +Inf/−0xFBFF.
REQ-026 SHALL produce subnormals by right-shifting the 24-bit significand and rounding per mode, including FP32 subnormal inputs; rounding carry from max subnormal gives min normal 0x0400.
REQ-027 SHALL set UF when the result is tiny before rounding and inexact; SHALL set NX whenever any discarded bit is nonzero.
REQ-028 SHALL update fflags_o only on output handshake: fflags = (clr ? 0 : fflags) | OR over lanes of flags_o; clear with a simultaneous handshake keeps only the new flags.

Reset
REQ-029 SHALL, while rst_ni=0, force pipeline valids to 0, out_valid_o=0, fflags_o=0, and data registers to 0; beats in flight are discarded.
REQ-030 SHALL drive in_ready_o=1 on the first cycle after reset release.

Structure
REQ-031 SHALL take rounding-mode enum, flag struct {nv,of,uf,nx}, and the FP16 constants (QNAN 0x7E00, INF 0x7C00, MAX 0x7BFF) from the shared package fp_conv_pkg.
REQ-032 SHALL instantiate LANES copies of the sub-module fp32_to_fp16_lane, split at the S1/S2 register boundary.

Verification
REQ-033 SHALL check: 0x3F800000, RNE -> 0x3C00, no flags, out_valid_o high 2 cycles after accept.
REQ-034 SHALL check: 0x3F801000 -> RNE 0x3C00 NX, RUP 0x3C01 NX; 0x3F803000 RNE -> 0x3C02 NX.
REQ-035 SHALL check: 0x47800000 -> RNE 0x7C00 OF|NX, RTZ 0x7BFF OF|NX; 0xC7800000 RUP -> 0xFBFF OF|NX.
REQ-036 SHALL check: 0x33800000 RNE -> 0x0001, no flags; 0x33000000 -> RNE 0x0000 UF|NX, RUP 0x0001 UF|NX.
REQ-037 SHALL check: 0x7F800001 -> 0x7E00 NV; 0x7FC00000 -> 0x7E00, no flags; fflags_o = NV after delivery, 0 after clear.
REQ-038 SHALL check: 6 beats streamed with out_ready_i low 5 cycles -> 2 held, in_ready_o low, then all delivered in order; rst_ni pulse mid-stream -> out_valid_o and fflags_o immediately 0.

Source files
------------

// File: rtl/fp_conv_pkg.sv
// fp_conv_pkg
// Types and constants shared by the FP32 -> FP16 conversion pipeline.
//   rm_e       : rounding-mode codes (RNE, RTZ, RDN, RUP, RMM)
//   fflags_t   : IEEE exception flags packed as {nv, of, uf, nx}
//   cls_e      : operand class resolved in the decode stage
//   s1_t       : everything the decode stage hands to the round stage
//   FP16_*     : FP16 bit patterns used for special results
//   decode_rm  : folds the unused rounding-mode codes onto RNE
package fp_conv_pkg;

  typedef enum logic [2:0] {
    RM_RNE = 3'd0,
    RM_RTZ = 3'd1,
    RM_RDN = 3'd2,
    RM_RUP = 3'd3,
    RM_RMM = 3'd4
  } rm_e;

  typedef struct packed {
    logic nv;
    logic of;
    logic uf;
    logic nx;
  } fflags_t;

  typedef enum logic [1:0] {
    CLS_ZERO,
    CLS_INF,
    CLS_NAN,
    CLS_FIN
  } cls_e;

  localparam logic [15:0] FP16_QNAN = 16'h7E00;
  localparam logic [15:0] FP16_INF  = 16'h7C00;
  localparam logic [15:0] FP16_MAX  = 16'h7BFF;

  // base holds {exp5, man10} before rounding; for tiny values exp5 is zero
  // and the mantissa is already shifted into subnormal position.
  typedef struct packed {
    logic [31:0] raw;
    fflags_t     flags_in;
    logic        sign;
    cls_e        cls;
    logic        ovf_pre;
    logic        tiny;
    logic [14:0] base;
    logic        guard;
    logic        sticky;
  } s1_t;

  // Codes above RMM have no meaning of their own and round to nearest-even.
  function automatic rm_e decode_rm(input logic [31:0] code);
    if (code > 32'd4) return RM_RNE;
    return rm_e'(code[2:0]);
  endfunction

endpackage

// File: rtl/fp32_to_fp16_lane.sv
// fp32_to_fp16_lane
// One conversion lane: decode/align into the S1 register, then round/pack
// into the S2 register. Stage loads are steered by the parent's handshake.
//   clk, rst_n        : clock, asynchronous active-low reset
//   load_s1, load_s2  : capture enables for the two stage registers
//   data, flags_in    : incoming FP32 operand and its {NV,OF,UF,NX} flags
//   rm, convert       : rounding mode and convert/passthrough of the S1 beat
//   result, flags     : registered lane result and flags
module fp32_to_fp16_lane
  import fp_conv_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_s1,
  input  logic        load_s2,
  input  logic [31:0] data,
  input  logic [3:0]  flags_in,
  input  rm_e         rm,
  input  logic        convert,
  output logic [31:0] result,
  output logic [3:0]  flags
);

  logic [7:0]  exp8;
  logic [7:0]  exp_eff;
  logic [7:0]  sub_shift;
  logic [4:0]  exp16;
  logic [4:0]  shamt;
  logic [23:0] sig24;
  logic [46:0] wide;
  s1_t         s1_d;
  s1_t         s1_q;

  logic        inexact;
  logic        inc;
  logic        ovf;
  logic        sat_max;
  logic [14:0] sum;
  logic [15:0] res16;
  fflags_t     cvt_flags;
  logic [31:0] result_d;
  logic [3:0]  flags_d;

  // Decode and align. FP32 subnormals are treated as exponent 1 without the
  // hidden bit. Values below the FP16 normal range get their significand
  // shifted right; shifts beyond 24 all behave the same (only sticky remains),
  // so the shift is capped there.
  always_comb begin
    exp8      = data[30:23];
    exp_eff   = (exp8 == 8'd0) ? 8'd1 : exp8;
    sig24     = {exp8 != 8'd0, data[22:0]};
    exp16     = 5'(exp_eff - 8'd112);
    sub_shift = 8'd113 - exp_eff;
    if (exp_eff >= 8'd113)      shamt = 5'd0;
    else if (sub_shift > 8'd24) shamt = 5'd24;
    else                        shamt = sub_shift[4:0];
    wide = 47'({sig24, 24'd0} >> shamt);

    s1_d          = '0;
    s1_d.raw      = data;
    s1_d.flags_in = fflags_t'(flags_in);
    s1_d.sign     = data[31];
    s1_d.ovf_pre  = (exp_eff >= 8'd143);
    s1_d.tiny     = (exp_eff < 8'd113);
    s1_d.base     = {(s1_d.tiny ? 5'd0 : exp16), wide[46:37]};
    s1_d.guard    = wide[36];
    s1_d.sticky   = |wide[35:0];
    if (exp8 == 8'hFF)
      s1_d.cls = (data[22:0] == 23'd0) ? CLS_INF : CLS_NAN;
    else if (exp8 == 8'd0 && data[22:0] == 23'd0)
      s1_d.cls = CLS_ZERO;
    else
      s1_d.cls = CLS_FIN;
  end

  // S1 register: holds the decoded beat while the round stage is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       s1_q <= '0;
    else if (load_s1) s1_q <= s1_d;
  end

  // Round and pack. Adding the increment to {exp, man} lets a mantissa carry
  // ripple into the exponent, which also turns the largest subnormal into
  // the smallest normal and the largest finite into infinity (overflow).
  always_comb begin
    inexact = s1_q.guard | s1_q.sticky;
    case (rm)
      RM_RTZ:  inc = 1'b0;
      RM_RDN:  inc = s1_q.sign & inexact;
      RM_RUP:  inc = ~s1_q.sign & inexact;
      RM_RMM:  inc = s1_q.guard;
      default: inc = s1_q.guard & (s1_q.sticky | s1_q.base[0]);
    endcase
    sum = s1_q.base + 15'(inc);
    ovf = s1_q.ovf_pre | (sum[14:10] == 5'h1F);
    case (rm)
      RM_RTZ:  sat_max = 1'b1;
      RM_RDN:  sat_max = ~s1_q.sign;
      RM_RUP:  sat_max = s1_q.sign;
      default: sat_max = 1'b0;
    endcase

    res16     = '0;
    cvt_flags = '0;
    case (s1_q.cls)
      CLS_ZERO: res16 = {s1_q.sign, 15'd0};
      CLS_INF:  res16 = {s1_q.sign, FP16_INF[14:0]};
      CLS_NAN: begin
        res16        = {s1_q.sign, FP16_QNAN[14:0] | {6'd0, s1_q.raw[21:13]}};
        cvt_flags.nv = ~s1_q.raw[22];
      end
      default: begin
        if (ovf) begin
          res16        = {s1_q.sign, sat_max ? FP16_MAX[14:0] : FP16_INF[14:0]};
          cvt_flags.of = 1'b1;
          cvt_flags.nx = 1'b1;
        end else begin
          res16        = {s1_q.sign, sum};
          cvt_flags.nx = inexact;
          cvt_flags.uf = s1_q.tiny & inexact;
        end
      end
    endcase

    if (convert) begin
      result_d = {16'd0, res16};
      flags_d  = cvt_flags;
    end else begin
      result_d = s1_q.raw;
      flags_d  = s1_q.flags_in;
    end
  end

  // S2 register: the lane's visible output, frozen while downstream stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result <= '0;
      flags  <= '0;
    end else if (load_s2) begin
      result <= result_d;
      flags  <= flags_d;
    end
  end

endmodule

// File: rtl/fp32_to_fp16_pipe.sv
// fp32_to_fp16_pipe
// Two-stage, LANES-wide FP32 -> FP16 converter with valid/ready flow control
// and a sticky exception-flag accumulator.
//   clk_i, rst_ni            : clock, asynchronous active-low reset
//   in_valid_i, in_ready_o   : input handshake
//   data_i, rm_i, mode_i     : operands, rounding mode, convert(1)/passthrough(0)
//   flags_i                  : per-lane incoming flags used in passthrough
//   out_valid_o, out_ready_i : output handshake
//   result_o, flags_o        : per-lane results and {NV,OF,UF,NX}
//   fflags_o, fflags_clr_i   : sticky OR of delivered flags and its clear
module fp32_to_fp16_pipe
  import fp_conv_pkg::*;
#(
  parameter int LANES   = 4,
  parameter int PARM_RM = 3
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [LANES*32-1:0]  data_i,
  input  logic [PARM_RM-1:0]   rm_i,
  input  logic                 mode_i,
  input  logic [LANES*4-1:0]   flags_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [LANES*32-1:0]  result_o,
  output logic [LANES*4-1:0]   flags_o,
  output logic [3:0]           fflags_o,
  input  logic                 fflags_clr_i
);

  logic       v1;
  logic       v2;
  logic       adv1;
  logic       adv2;
  logic       load1;
  logic       load2;
  rm_e        rm_q;
  logic       mode_q;
  logic [3:0] beat_flags;

  // A stage may take new data when it is empty or the stage after it moves.
  assign adv2        = ~v2 | out_ready_i;
  assign adv1        = ~v1 | adv2;
  assign load1       = adv1 & in_valid_i;
  assign load2       = adv2 & v1;
  assign in_ready_o  = adv1;
  assign out_valid_o = v2;

  // Valid bits, the per-beat mode carried alongside S1, and the sticky flags.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      v1       <= 1'b0;
      v2       <= 1'b0;
      rm_q     <= RM_RNE;
      mode_q   <= 1'b0;
      fflags_o <= '0;
    end else begin
      if (adv1) v1 <= in_valid_i;
      if (adv2) v2 <= v1;
      if (load1) begin
        rm_q   <= decode_rm(32'(rm_i));
        mode_q <= mode_i;
      end
      if (out_valid_o && out_ready_i)
        fflags_o <= (fflags_clr_i ? 4'd0 : fflags_o) | beat_flags;
      else if (fflags_clr_i)
        fflags_o <= '0;
    end
  end

  // Flags of the beat currently on the output, merged across lanes.
  always_comb begin
    beat_flags = '0;
    for (int k = 0; k < LANES; k++) beat_flags |= flags_o[4*k +: 4];
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    fp32_to_fp16_lane u_lane (
      .clk      (clk_i),
      .rst_n    (rst_ni),
      .load_s1  (load1),
      .load_s2  (load2),
      .data     (data_i[32*k +: 32]),
      .flags_in (flags_i[4*k +: 4]),
      .rm       (rm_q),
      .convert  (mode_q),
      .result   (result_o[32*k +: 32]),
      .flags    (flags_o[4*k +: 4])
    );
  end

endmodule
